// File: rtl/pprr_wrr_arbiter.sv
// Weighted round-robin arbiter: parallel-prefix winner search, per-grant credit
// burst, back-to-back re-arbitration on release with no idle bubble.
module pprr_wrr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned WW = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic [N*WW-1:0]      i_weight,
  input  logic                 i_ready,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_idx,
  output logic                 o_ag
);

  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]  g_q, g_d;
  logic [IW-1:0] p_q, p_d;
  logic [WW-1:0] c_q, c_d;

  logic [IW-1:0] cur_idx, arb_ptr, win_idx;
  logic [N-1:0]  win_oh;
  logic          busy, release_now;

  // Prefix-OR over log2(N) doubling shifts; a bit survives only if nothing below it is set.
  function automatic logic [N-1:0] lowest_set(input logic [N-1:0] r);
    logic [N-1:0] s;
    s = r;
    for (int unsigned d = 1; d < N; d = d * 2) s = s | (s << d);
    return r & ~(s << 1);
  endfunction

  function automatic logic [N-1:0] ge_mask(input logic [IW-1:0] p);
    logic [N-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < N; k++) m[k] = (k >= 32'(p));
    return m;
  endfunction

  function automatic logic [N-1:0] winner_oh(input logic [IW-1:0] p, input logic [N-1:0] r);
    logic [N-1:0] hi;
    hi = r & ge_mask(p);
    return lowest_set((|hi) ? hi : r);
  endfunction

  function automatic logic [IW-1:0] encode(input logic [N-1:0] v);
    logic [IW-1:0] e;
    e = '0;
    for (int unsigned k = 0; k < N; k++) if (v[k]) e = e | IW'(k);
    return e;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
    return (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
  endfunction

  function automatic logic [WW-1:0] eff_weight(input logic [IW-1:0] idx,
                                               input logic [N*WW-1:0] w_vec);
    logic [WW-1:0] w;
    w = w_vec[idx*WW +: WW];
    return (w == '0) ? WW'(1) : w;
  endfunction

  always_comb begin
    cur_idx     = encode(g_q);
    busy        = |g_q;
    release_now = busy && (!i_req[cur_idx] || (i_ready && (c_q <= WW'(1))));
    arb_ptr     = busy ? next_ptr(cur_idx) : p_q;
    win_oh      = winner_oh(arb_ptr, i_req);
    win_idx     = encode(win_oh);

    g_d = g_q;
    p_d = p_q;
    c_d = c_q;
    if (!busy) begin
      if (|i_req) begin
        g_d = win_oh;
        c_d = eff_weight(win_idx, i_weight);
      end
    end else if (release_now) begin
      p_d = arb_ptr;
      g_d = win_oh;
      c_d = (|i_req) ? eff_weight(win_idx, i_weight) : '0;
    end else if (i_ready) begin
      c_d = c_q - WW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      g_q <= '0;
      p_q <= '0;
      c_q <= '0;
    end else begin
      g_q <= g_d;
      p_q <= p_d;
      c_q <= c_d;
    end
  end

  assign o_grant     = g_q;
  assign o_grant_idx = cur_idx;
  assign o_ag        = busy;

endmodule

// File: doc/pprr_wrr_arbiter.md
PPRR_WRR_ARBITER -- requirements
Module: pprr_wrr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of requesters (N >= 2).
REQ-002 The block SHALL have parameter WW, default 4, giving the width of each per-requester weight.
REQ-003 Port i_clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 Port i_req, input, N bits, SHALL carry one request bit per requester; bit k belongs to requester k.
REQ-006 Port i_weight, input, N*WW bits, SHALL carry the weight of requester k in bits [k*WW +: WW].
REQ-007 Port i_ready, input, 1 bit, SHALL mark acceptance of one beat by the current grantee.
REQ-008 Port o_grant, output, N bits, SHALL be the registered one-hot or zero grant vector.
REQ-009 Port o_grant_idx, output, clog2(N) bits, SHALL be the binary index of the set o_grant bit (0 when o_grant is 0).
REQ-010 Port o_ag, output, 1 bit, SHALL be the OR of o_grant ("any grant").

Function
REQ-011 Internal state SHALL consist of grant register G (N bits), priority pointer P (clog2(N) bits) and credit counter C (WW bits).
REQ-012 winner(p, r) SHALL be the lowest index k >= p with r[k]=1, else the lowest k < p with r[k]=1 (wrap-around). It SHALL be computed combinationally by parallel-prefix (log2 N levels), not a serial loop.
REQ-013 Effective weight SHALL be max(i_weight[k], 1); weight 0 SHALL behave as 1.
REQ-014 IDLE (G=0) with i_req=0: all state SHALL hold.
REQ-015 IDLE with i_req != 0: at the next edge, G <= onehot(winner(P, i_req)) and C <= effective weight of that winner.
REQ-016 GRANT (G=onehot(g)) with i_req[g]=1 and i_ready=0: G, C and P SHALL hold; weights are not re-sampled.
REQ-017 GRANT with i_req[g]=1, i_ready=1 and C>1: C <= C-1; G and P SHALL hold (burst continues).
REQ-018 GRANT with i_req[g]=1, i_ready=1 and C=1: release. P <= (g+1) mod N, and in the same edge G <= onehot(winner((g+1) mod N, i_req)), or 0 if no request, with C reloaded; there is no idle bubble between grants.
REQ-019 GRANT with i_req[g]=0 (withdrawal): release regardless of i_ready and C, per REQ-018.
REQ-020 When a release finds g as the only requester, g SHALL be re-granted with C reloaded.
REQ-021 o_grant SHALL equal G, o_grant_idx SHALL be the encoded G, and o_ag SHALL equal |G; all driven from registers with no combinational path from inputs.
REQ-022 o_grant SHALL never have more than one bit set.
REQ-023 A grant latency of exactly one clock from request to o_grant SHALL apply when idle.

Reset
REQ-024 i_rst=1 SHALL immediately (asynchronously) force G=0, P=0, C=0, hence o_grant=0, o_grant_idx=0 and o_ag=0.
REQ-025 Reset asserted mid-burst SHALL discard the burst; after deassertion, arbitration SHALL restart from P=0 at the first rising edge.

Verification (N=8, WW=4)
REQ-026 Async reset: assert i_rst between edges while o_grant=0x08 -> o_grant=0, o_ag=0 before the next edge; release with i_req=0x01 -> o_grant=0x01 one edge later.
REQ-027 Round-robin: all weights 1, i_req=0x48 constant, i_ready=1 -> o_grant sequence 0x08, 0x40, 0x08, 0x40, ...; o_grant_idx 3, 6, 3, 6.
REQ-028 Weighting: weight[3]=3, weight[6]=1, i_req=0x48, i_ready=1 -> o_grant 0x08 for 3 cycles, then 0x40 for 1 cycle, repeating.
REQ-029 Backpressure: weight[3]=2, i_req=0x08, i_ready pattern 1,0,0,1 -> o_grant stays 0x08 for all 4 cycles; release occurs on the 4th, then 0x08 is re-granted (sole requester).
REQ-030 Withdrawal and weight zero: weight[3]=5, i_req=0x48, drop i_req[3] in the 2nd grant cycle -> next o_grant=0x40. Separately, weight[1]=0 with i_req=0x02 -> one-cycle grants per REQ-013.
REQ-031 Wrap: all weights 1, i_req=0x81 from reset -> o_grant 0x01, 0x80, 0x01; P wraps from 7 to 0.
